square_spawn_ctrl: RTL and testbench

Game-flow controller that sequences the `random_square` datapath. It owns the 640-bit square position register and feeds it back to `random_square` each frame. It drives `status` and `num_squares`, adding squares on a frame-count schedule that speeds up with level. It freezes play on collision. It sits between the VGA frame-tick generator, the player/collision logic and `random_square`.

---
 rtl/square_spawn_ctrl.sv | 100 ++++++++++
 tb/tb_square_spawn_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/square_spawn_ctrl.sv
// square_spawn_ctrl: game-flow FSM spawning squares on a frame schedule; define SQ_CTRL_PAUSE_EN to add a pause input/state
module square_spawn_ctrl #(
  parameter int MAX_SQUARES       = 16,
  parameter int INIT_INTERVAL     = 120,
  parameter int MIN_INTERVAL      = 30,
  parameter int INTERVAL_STEP     = 10,
  parameter int SQUARES_PER_LEVEL = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      refresh_tick,
  input  logic                      start,
  input  logic                      collision,
`ifdef SQ_CTRL_PAUSE_EN
  input  logic                      pause,
`endif
  input  logic [MAX_SQUARES*40-1:0] position_next,
  output logic [MAX_SQUARES*40-1:0] position,
  output logic                      status,
  output logic [5:0]                num_squares,
  output logic [3:0]                level,
  output logic                      game_over
);
  localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2;
`ifdef SQ_CTRL_PAUSE_EN
  localparam logic [1:0] PAUSE = 2'd3;
`endif
  localparam logic [5:0] MAX_N  = 6'(MAX_SQUARES);
  localparam logic [7:0] INIT_I = 8'(INIT_INTERVAL);
  localparam logic [7:0] MIN_I  = 8'(MIN_INTERVAL);
  localparam logic [7:0] STEP_I = 8'(INTERVAL_STEP);
  localparam logic [7:0] SPL_M  = 8'(SQUARES_PER_LEVEL - 1);
  localparam logic [8:0] FLOOR  = 9'(MIN_INTERVAL + INTERVAL_STEP);
  logic [1:0] state;
  logic [7:0] cnt, interval, smod;
  logic       wrap, spawn, lvl_up;
  // spawn happens when the frame counter wraps and a slot is still free
  always_comb begin
    wrap   = cnt == interval - 8'd1;
    spawn  = wrap && num_squares < MAX_N;
    lvl_up = spawn && smod == SPL_M;
  end
  // game state, spawn schedule and registered outputs
  always_ff @(posedge clk)
    if (!reset) begin
      state       <= IDLE;
      position    <= '0;
      status      <= 1'b0;
      num_squares <= '0;
      level       <= '0;
      game_over   <= 1'b0;
      cnt         <= '0;
      interval    <= INIT_I;
      smod        <= '0;
    end else begin
      case (state)
        IDLE, OVER: if (start) begin
          state       <= PLAY;
          position    <= '0;
          status      <= 1'b1;
          num_squares <= 6'd1;
          level       <= '0;
          game_over   <= 1'b0;
          cnt         <= '0;
          interval    <= INIT_I;
          smod        <= '0;
        end
        PLAY: if (collision) begin
          state     <= OVER;
          status    <= 1'b0;
          game_over <= 1'b1;
        end
`ifdef SQ_CTRL_PAUSE_EN
        else if (pause) begin
          state  <= PAUSE;
          status <= 1'b0;
        end
`endif
        else if (refresh_tick) begin
          position <= position_next;
          cnt      <= wrap ? '0 : cnt + 8'd1;
          if (spawn) begin
            num_squares <= num_squares + 6'd1;
            smod        <= lvl_up ? '0 : smod + 8'd1;
          end
          if (lvl_up) begin
            level    <= level == 4'hf ? level : level + 4'd1;
            interval <= {1'b0, interval} >= FLOOR ? interval - STEP_I : MIN_I;
          end
        end
`ifdef SQ_CTRL_PAUSE_EN
        PAUSE: if (pause) begin
          state  <= PLAY;
          status <= 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_square_spawn_ctrl.sv
// tb_square_spawn_ctrl: directed self-checking bench for square_spawn_ctrl (pause checks under SQ_CTRL_PAUSE_EN)
module tb_square_spawn_ctrl;
  logic         clk = 0, reset = 0, refresh_tick = 0, start = 0, collision = 0;
`ifdef SQ_CTRL_PAUSE_EN
  logic         pause = 0;
`endif
  logic [639:0] position_next = '0, position;
  logic         status, game_over;
  logic [5:0]   num_squares;
  logic [3:0]   level;
  logic [639:0] pat_a, pat_c, pat_b;
  int           checks = 0, errors = 0;

  square_spawn_ctrl #(
    .MAX_SQUARES(16), .INIT_INTERVAL(4), .MIN_INTERVAL(3),
    .INTERVAL_STEP(1), .SQUARES_PER_LEVEL(2)
  ) dut (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .start(start),
    .collision(collision),
`ifdef SQ_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .position_next(position_next), .position(position), .status(status),
    .num_squares(num_squares), .level(level), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk) refresh_tick = 1;
    @(negedge clk) refresh_tick = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pos"}, position, '0);
    check({tag, "_status"}, status, 0);
    check({tag, "_num"}, num_squares, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_over"}, game_over, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    pat_a = {80{8'h5A}};
    pat_c = {80{8'hC3}};
    pat_b = {160{4'hB}};
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1;
    position_next = pat_a;
    tick();
    tick();
    check_zero("idle_tick");

    pulse_start();
    check("start_status", status, 1);
    check("start_num", num_squares, 1);
    check("start_over", game_over, 0);
    tick();
    check("tick_pos", position, pat_a);
    check("tick1_num", num_squares, 1);
    for (int i = 2; i <= 14; i++) begin
      tick();
      if (i == 3)  check("t3_num", num_squares, 1);
      if (i == 4)  check("t4_num", num_squares, 2);
      if (i == 7)  begin check("t7_num", num_squares, 2); check("t7_level", level, 0); end
      if (i == 8)  begin check("t8_num", num_squares, 3); check("t8_level", level, 1); end
      if (i == 10) check("t10_num", num_squares, 3);
      if (i == 11) check("t11_num", num_squares, 4);
      if (i == 13) check("t13_num", num_squares, 4);
      if (i == 14) begin check("t14_num", num_squares, 5); check("t14_level", level, 2); end
    end

    @(negedge clk) reset = 0;
    @(negedge clk);
    check_zero("midreset");
    reset = 1;

    pulse_start();
    for (int i = 1; i <= 47; i++) begin
      tick();
      if (i == 46) check("t46_num", num_squares, 15);
      if (i == 47) begin check("t47_num", num_squares, 16); check("t47_level", level, 7); end
    end
    repeat (200) tick();
    check("sat_num", num_squares, 16);
    check("sat_level", level, 7);
    check("sat_status", status, 1);

    position_next = pat_c;
    @(negedge clk) begin collision = 1; refresh_tick = 1; end
    @(negedge clk) refresh_tick = 0;
    check("col_over", game_over, 1);
    check("col_status", status, 0);
    check("col_pos", position, pat_a);
    check("col_num", num_squares, 16);
    check("col_level", level, 7);
    tick();
    check("over_hold_pos", position, pat_a);

    @(negedge clk) start = 1;
    @(negedge clk) begin start = 0; collision = 0; end
    check("restart_pos", position, '0);
    check("restart_num", num_squares, 1);
    check("restart_level", level, 0);
    check("restart_status", status, 1);
    check("restart_over", game_over, 0);

`ifdef SQ_CTRL_PAUSE_EN
    position_next = pat_b;
    @(negedge clk) pause = 1;
    @(negedge clk) pause = 0;
    check("pause_status", status, 0);
    repeat (10) tick();
    check("pause_pos", position, '0);
    check("pause_num", num_squares, 1);
    @(negedge clk) pause = 1;
    @(negedge clk) pause = 0;
    check("resume_status", status, 1);
    tick();
    check("resume_pos", position, pat_b);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
